// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the default-slave state type used by the read-return mux.
// The bus-width fallback below matches ahb_defines.v so each file also compiles standalone.
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

package ahb_pkg;

    localparam logic [1:0] AHB_OKAY   = 2'b00;
    localparam logic [1:0] AHB_ERROR  = 2'b01;
    localparam logic [1:0] AHB_RETRY  = 2'b10;
    localparam logic [1:0] AHB_SPLIT  = 2'b11;

    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // True for transfer types that demand a real response (NONSEQ/SEQ).
    function automatic logic is_xfer(input logic [1:0] htrans);
        return (htrans == AHB_NONSEQ) || (htrans == AHB_SEQ);
    endfunction

endpackage

// File: rtl/ahb_read_mux_if.sv
// Slave-to-master return-path bundle; "master" drives the inputs of the mux, "slave" is the mux.
// Adds HTIMEOUT_o when AHB_READ_TIMEOUT_EN is defined.
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

interface ahb_read_mux_if #(
    parameter int NSLV      = 16,
    parameter int SLV_IDX_W = 4
);
    logic [NSLV-1:0]           HSEL_i;
    logic [1:0]                HTRANS_i;
    logic [`AHB_BUS_WIDTH-1:0] HRDATA_i [NSLV-1:0];
    logic [NSLV-1:0]           HREADYOUT_i;
    logic [1:0]                HRESP_i [NSLV-1:0];

    logic [`AHB_BUS_WIDTH-1:0] HRDATA_o;
    logic                      HREADY_o;
    logic [1:0]                HRESP_o;
    logic [SLV_IDX_W-1:0]      HSLAVE_o;
    logic                      HDEF_o;
`ifdef AHB_READ_TIMEOUT_EN
    logic                      HTIMEOUT_o;
`endif

    modport master (
        output HSEL_i, HTRANS_i, HRDATA_i, HREADYOUT_i, HRESP_i,
`ifdef AHB_READ_TIMEOUT_EN
        input  HTIMEOUT_o,
`endif
        input  HRDATA_o, HREADY_o, HRESP_o, HSLAVE_o, HDEF_o
    );

    modport slave (
        input  HSEL_i, HTRANS_i, HRDATA_i, HREADYOUT_i, HRESP_i,
`ifdef AHB_READ_TIMEOUT_EN
        output HTIMEOUT_o,
`endif
        output HRDATA_o, HREADY_o, HRESP_o, HSLAVE_o, HDEF_o
    );
endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave: two-cycle ERROR for unmapped NONSEQ/SEQ transfers.
// With AHB_READ_TIMEOUT_EN it also aborts a real slave stuck in wait states.
module ahb_default_slave
    import ahb_pkg::*;
`ifdef AHB_READ_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic       HCLK,
    input  logic       HRST_N,
    input  logic       hready_i,     // bus HREADY: address phase is sampled when high
    input  logic       unmapped_i,   // NONSEQ/SEQ with no slave selected
`ifdef AHB_READ_TIMEOUT_EN
    input  logic       slv_phase_i,  // current data phase belongs to a real slave
    output logic       force_def_o,  // abort this edge: hand the data phase to us
    output logic       timeout_o,
`endif
    output logic       ds_hready_o,
    output logic [1:0] ds_hresp_o
);

    ds_state_t state_q;
    logic      abort;

`ifdef AHB_READ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_q;
    logic             waiting;

    assign waiting     = slv_phase_i && !hready_i;
    assign abort       = waiting && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign force_def_o = abort;

    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            wait_q    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= abort;
            if (!waiting || abort) wait_q <= '0;
            else                   wait_q <= wait_q + 1'b1;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // NOTE: state and its decoded outputs update together with non-blocking assignments,
    // so every reader sees the pre-edge values and the outputs are glitch-free flops.
    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            state_q     <= DS_IDLE;
            ds_hready_o <= 1'b1;
            ds_hresp_o  <= AHB_OKAY;
        end else if (abort || (state_q != DS_ERR1 && hready_i && unmapped_i)) begin
            state_q     <= DS_ERR1;
            ds_hready_o <= 1'b0;
            ds_hresp_o  <= AHB_ERROR;
        end else begin
            case (state_q)
                DS_ERR1: begin
                    state_q     <= DS_ERR2;
                    ds_hready_o <= 1'b1;
                    ds_hresp_o  <= AHB_ERROR;
                end
                DS_ERR2: begin
                    state_q     <= DS_IDLE;
                    ds_hready_o <= 1'b1;
                    ds_hresp_o  <= AHB_OKAY;
                end
                default: begin
                    state_q     <= DS_IDLE;
                    ds_hready_o <= 1'b1;
                    ds_hresp_o  <= AHB_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_read_mux.sv
// AHB return-path mux: registers the address-phase decode and steers the owning slave's
// response to the masters. Optional wait-state timeout via AHB_READ_TIMEOUT_EN.
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif

module ahb_read_mux
    import ahb_pkg::*;
#(
    parameter int NSLV           = 16,
    parameter int SLV_IDX_W      = 4,
    parameter int TIMEOUT_CYCLES = 256
)
(
    input  logic           HCLK,
    input  logic           HRST_N,
    ahb_read_mux_if.slave  bus
);

    if (NSLV < 1 || NSLV > 16 || (1 << SLV_IDX_W) < NSLV || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ahb_read_mux: invalid NSLV/SLV_IDX_W/TIMEOUT_CYCLES");
    end

    logic [SLV_IDX_W-1:0]      sel_q, sel_d;
    logic                      def_q, def_d;
    logic [SLV_IDX_W-1:0]      low_idx;
    logic                      any_sel;
    logic                      unmapped;
    logic                      force_def;
    logic                      ds_hready;
    logic [1:0]                ds_hresp;
    logic [`AHB_BUS_WIDTH-1:0] hrdata;
    logic                      hready;
    logic [1:0]                hresp;

    assign any_sel  = |bus.HSEL_i;
    assign unmapped = !any_sel && is_xfer(bus.HTRANS_i);

    // Lowest set bit wins so a faulty multi-hot decode still picks exactly one slave.
    always_comb begin
        low_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (bus.HSEL_i[i]) low_idx = SLV_IDX_W'(i);
        end
    end

    ahb_default_slave
`ifdef AHB_READ_TIMEOUT_EN
    #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_def (
        .HCLK        (HCLK),
        .HRST_N      (HRST_N),
        .hready_i    (hready),
        .unmapped_i  (unmapped),
`ifdef AHB_READ_TIMEOUT_EN
        .slv_phase_i (!def_q),
        .force_def_o (force_def),
        .timeout_o   (bus.HTIMEOUT_o),
`endif
        .ds_hready_o (ds_hready),
        .ds_hresp_o  (ds_hresp)
    );

`ifndef AHB_READ_TIMEOUT_EN
    assign force_def = 1'b0;
`endif

    // NOTE: next-state defaults to the current value first, so no path leaves it unassigned
    // and no latch can be inferred.
    always_comb begin
        sel_d = sel_q;
        def_d = def_q;
        if (hready) begin
            if (any_sel) begin
                sel_d = low_idx;
                def_d = 1'b0;
            end else begin
                def_d = 1'b1;
            end
        end
        if (force_def) def_d = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            sel_q <= '0;
            def_q <= 1'b1;
        end else begin
            sel_q <= sel_d;
            def_q <= def_d;
        end
    end

    // Response path is purely combinational from the registered owner: zero added latency.
    always_comb begin
        if (def_q) begin
            hrdata = '0;
            hready = ds_hready;
            hresp  = ds_hresp;
        end else begin
            hrdata = bus.HRDATA_i[sel_q];
            hready = bus.HREADYOUT_i[sel_q];
            hresp  = bus.HRESP_i[sel_q];
        end
    end

    assign bus.HRDATA_o = hrdata;
    assign bus.HREADY_o = hready;
    assign bus.HRESP_o  = hresp;
    assign bus.HSLAVE_o = sel_q;
    assign bus.HDEF_o   = def_q;

endmodule

// File: tb/tb_ahb_read_mux.sv
// Self-checking bench for ahb_read_mux: directed scenarios plus random traffic against a
// transaction-level model of data-phase ownership and the two-cycle ERROR response.
`ifndef AHB_BUS_WIDTH
`define AHB_BUS_WIDTH 32
`endif
`timescale 1ns/1ps

module tb_ahb_read_mux;
    import ahb_pkg::*;

    localparam int NSLV      = 16;
    localparam int SLV_IDX_W = 4;
    localparam int TMO       = 8;
    localparam int W         = `AHB_BUS_WIDTH;

    logic HCLK = 1'b0;
    logic HRST_N;
    always #5 HCLK = ~HCLK;

    ahb_read_mux_if #(.NSLV(NSLV), .SLV_IDX_W(SLV_IDX_W)) bus ();

    ahb_read_mux #(.NSLV(NSLV), .SLV_IDX_W(SLV_IDX_W), .TIMEOUT_CYCLES(TMO)) dut (
        .HCLK   (HCLK),
        .HRST_N (HRST_N),
        .bus    (bus)
    );

    // Stimulus held by the bench
    logic [NSLV-1:0] t_hsel;
    logic [1:0]      t_htrans;
    logic [W-1:0]    s_rdata [NSLV];
    logic [NSLV-1:0] s_rdy;
    logic [1:0]      s_resp  [NSLV];

    // Reference model: who owns the data phase and how many ERROR cycles remain
    int m_owner;   // -1 = default slave
    int m_err;     // 2 = first ERROR cycle (wait), 1 = second ERROR cycle, 0 = none
    int m_slave;
    int m_wait;
    bit m_pulse;
    int n_pulses;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NSLV-1:0] v);
        for (int i = 0; i < NSLV; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic model_ready();
        if (m_owner >= 0) return s_rdy[m_owner];
        return (m_err != 2);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_err   = 0;
        m_slave = 0;
        m_wait  = 0;
        m_pulse = 0;
    endtask

    task automatic model_clock();
        logic rdy;
        rdy     = model_ready();
        m_pulse = 0;
        if (rdy) begin
            m_wait = 0;
            if (t_hsel != '0) begin
                m_owner = lowest(t_hsel);
                m_slave = m_owner;
                m_err   = 0;
            end else begin
                m_owner = -1;
                m_err   = (t_htrans == AHB_NONSEQ || t_htrans == AHB_SEQ) ? 2 : 0;
            end
        end else if (m_owner < 0) begin
            m_err = 1;
        end else begin
            m_wait++;
`ifdef AHB_READ_TIMEOUT_EN
            if (m_wait == TMO) begin
                m_owner = -1;
                m_err   = 2;
                m_wait  = 0;
                m_pulse = 1;
            end
`endif
        end
    endtask

    task automatic apply();
        bus.HSEL_i      = t_hsel;
        bus.HTRANS_i    = t_htrans;
        bus.HREADYOUT_i = s_rdy;
        for (int i = 0; i < NSLV; i++) begin
            bus.HRDATA_i[i] = s_rdata[i];
            bus.HRESP_i[i]  = s_resp[i];
        end
    endtask

    task automatic compare_outputs();
        logic [W-1:0] e_data;
        logic [1:0]   e_resp;
        if (m_owner >= 0) begin
            e_data = s_rdata[m_owner];
            e_resp = s_resp[m_owner];
        end else begin
            e_data = '0;
            e_resp = (m_err != 0) ? AHB_ERROR : AHB_OKAY;
        end
        check("hready", bus.HREADY_o, model_ready());
        check("hresp",  bus.HRESP_o,  e_resp);
        check("hrdata", bus.HRDATA_o, e_data);
        check("hdef",   bus.HDEF_o,   (m_owner < 0));
        check("hslave", bus.HSLAVE_o, m_slave);
`ifdef AHB_READ_TIMEOUT_EN
        check("htimeout", bus.HTIMEOUT_o, m_pulse);
        if (bus.HTIMEOUT_o === 1'b1) n_pulses++;
`endif
    endtask

    // Each step starts just after a rising edge: drive, check mid-cycle, then clock the model.
    task automatic half_a();
        apply();
        @(negedge HCLK);
        compare_outputs();
    endtask

    task automatic half_b();
        @(posedge HCLK);
        model_clock();
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic do_reset();
        HRST_N = 1'b0;
        #1;
        model_reset();
        check("rst_hready", bus.HREADY_o, 1'b1);
        check("rst_hresp",  bus.HRESP_o,  AHB_OKAY);
        check("rst_hdef",   bus.HDEF_o,   1'b1);
        check("rst_hrdata", bus.HRDATA_o, '0);
        check("rst_hslave", bus.HSLAVE_o, '0);
`ifdef AHB_READ_TIMEOUT_EN
        check("rst_htimeout", bus.HTIMEOUT_o, 1'b0);
`endif
        @(posedge HCLK);
        #1;
        HRST_N = 1'b1;
    endtask

    task automatic set_addr(input logic [NSLV-1:0] hsel, input logic [1:0] htrans);
        t_hsel   = hsel;
        t_htrans = htrans;
    endtask

    initial begin
        n_pulses = 0;
        t_hsel   = '0;
        t_htrans = AHB_IDLE;
        s_rdy    = '1;
        for (int i = 0; i < NSLV; i++) begin
            s_rdata[i] = $urandom;
            s_resp[i]  = AHB_OKAY;
        end
        apply();
        @(negedge HCLK);
        do_reset();

        // Slave 3 with two wait states
        set_addr(16'h0008, AHB_NONSEQ);
        step();
        set_addr('0, AHB_IDLE);
        s_rdata[3] = 32'hDEADBEEF;
        s_rdy[3]   = 1'b0;
        step();
        step();
        s_rdy[3] = 1'b1;
        half_a();
        check("t1_rdata",  bus.HRDATA_o, 32'hDEADBEEF);
        check("t1_hslave", bus.HSLAVE_o, 3);
        half_b();

        // Unmapped NONSEQ: ERROR/wait, ERROR/ready, then OKAY
        set_addr('0, AHB_NONSEQ);
        step();
        set_addr('0, AHB_IDLE);
        half_a();
        check("t2_err1_ready", bus.HREADY_o, 1'b0);
        check("t2_err1_resp",  bus.HRESP_o,  AHB_ERROR);
        half_b();
        step();
        step();

        // Unmapped IDLE and BUSY: zero-wait OKAY
        set_addr('0, AHB_BUSY);
        step();
        step();

        // Slave 0 stalls while the decoder already points at slave 5
        set_addr(16'h0001, AHB_NONSEQ);
        step();
        s_rdy[0] = 1'b0;
        set_addr(16'h0020, AHB_NONSEQ);
        for (int k = 0; k < 3; k++) step();
        s_rdy[0] = 1'b1;
        step();
        set_addr('0, AHB_IDLE);
        s_rdata[5] = 32'h5555_A5A5;
        half_a();
        check("t4_hslave", bus.HSLAVE_o, 5);
        check("t4_rdata",  bus.HRDATA_o, 32'h5555_A5A5);
        half_b();

        // Multi-hot decode: lowest index wins
        set_addr(16'h0030, AHB_SEQ);
        step();
        set_addr('0, AHB_IDLE);
        half_a();
        check("t5_hslave", bus.HSLAVE_o, 4);
        half_b();

        // Back-to-back slave then unmapped, then reset during the first ERROR cycle
        set_addr(16'h0002, AHB_NONSEQ);
        step();
        set_addr('0, AHB_SEQ);
        step();
        set_addr('0, AHB_IDLE);
        half_a();
        do_reset();
        step();

`ifdef AHB_READ_TIMEOUT_EN
        // Slave 2 never becomes ready: timeout after TMO wait cycles, a single pulse
        n_pulses = 0;
        set_addr(16'h0004, AHB_NONSEQ);
        step();
        set_addr('0, AHB_IDLE);
        s_rdy[2] = 1'b0;
        for (int k = 0; k < TMO + 5; k++) step();
        check("tmo_pulses", n_pulses, 1);
        s_rdy[2] = 1'b1;
        step();
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      t_hsel = '0;
            else if (r < 8) t_hsel = NSLV'(1) << $urandom_range(0, NSLV - 1);
            else            t_hsel = NSLV'($urandom);
            t_htrans = 2'($urandom_range(0, 3));
            for (int i = 0; i < NSLV; i++) begin
                s_rdata[i] = $urandom;
                s_resp[i]  = 2'($urandom_range(0, 3));
                s_rdy[i]   = ($urandom_range(0, 3) != 0);
            end
            if (c == 200) do_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_read_mux.md
Name: ahb_read_mux

Overview:
Slave-to-master response multiplexer for the shared AHB bus. It is the return-path counterpart of the master-side address/write-data mux.
- Registers the address-phase slave decode into the data phase.
- Steers the selected slave's HRDATA/HREADYOUT/HRESP back to the masters.
- Contains a built-in default slave that answers unmapped accesses with the two-cycle ERROR response.

Parameters:
- NSLV, 16, number of slave ports (1..16).
- SLV_IDX_W, 4, width of the registered slave index; must satisfy 2^SLV_IDX_W >= NSLV.
- TIMEOUT_CYCLES, 256, data-phase wait-state limit; used only with AHB_READ_TIMEOUT_EN.

Ports:
- HCLK  in  1  bus clock.
- HRST_N  in  1  asynchronous active-low reset.
- HSEL_i  in  NSLV  address-phase decoder one-hot slave select.
- HTRANS_i  in  2  muxed address-phase HTRANS.
- HRDATA_i  in  `AHB_BUS_WIDTH x NSLV  per-slave read data (unpacked array [NSLV-1:0]).
- HREADYOUT_i  in  NSLV  per-slave ready.
- HRESP_i  in  2 x NSLV  per-slave response.
- HRDATA_o  out  `AHB_BUS_WIDTH  read data to all masters.
- HREADY_o  out  1  bus HREADY; fed back to masters, slaves, arbiter and write mux.
- HRESP_o  out  2  response to masters.
- HSLAVE_o  out  SLV_IDX_W  data-phase slave index (debug/arbiter).
- HDEF_o  out  1  data phase owned by the default slave.

Behaviour:
- Reset (async, HRST_N=0):
  - data-phase select = default slave, HDEF_o=1, HSLAVE_o=0.
  - HREADY_o=1, HRESP_o=OKAY(2'b00), HRDATA_o=0.
  - default-slave FSM in DS_IDLE.
- HRESP encoding (AHB2): OKAY=00, ERROR=01, RETRY=10, SPLIT=11.
- Address-phase sampling happens only on posedge HCLK with HREADY_o=1. While HREADY_o=0 the select register holds.
- Decode:
  - Any HSEL_i bit set: HSLAVE_o <= lowest set index, HDEF_o <= 0.
  - No bit set: HDEF_o <= 1.
  - Multiple bits set: lowest index wins; this is a decoder bug and must not hang the bus.
- Data-phase output is combinational from the registered select:
  - HDEF_o=0: HRDATA_o/HREADY_o/HRESP_o = slave[HSLAVE_o] signals.
  - HDEF_o=1: HRDATA_o=0, and HREADY_o/HRESP_o come from the default-slave FSM.
- Default-slave FSM (states DS_IDLE, DS_ERR1, DS_ERR2):
  - DS_IDLE: HREADY=1, HRESP=OKAY.
    - Goes to DS_ERR1 when an address phase is sampled with no HSEL and HTRANS_i = NONSEQ(10) or SEQ(11).
    - IDLE(00)/BUSY(01) to no slave: stays DS_IDLE, zero-wait OKAY.
  - DS_ERR1: HREADY=0, HRESP=ERROR. Always goes to DS_ERR2.
  - DS_ERR2: HREADY=1, HRESP=ERROR.
    - Address sampled this cycle: unmapped NONSEQ/SEQ goes to DS_ERR1, otherwise DS_IDLE.
- Back-to-back: an unmapped access immediately following a slave access starts DS_ERR1 in the cycle after the slave's HREADYOUT=1; there are no bubble cycles.
- Slave wait states pass through unchanged and are unlimited unless the timeout option is enabled.
- Reset mid-transfer: all state returns to reset values within the same cycle; slave outputs are ignored until the next sampled address phase.
- Latency: zero added cycles on the response path; select register is 1 cycle (address phase to data phase).

Optional Feature:
- Macro: AHB_READ_TIMEOUT_EN.
- Defined:
  - A wait counter increments each cycle a non-default data phase has HREADY_o=0, and clears when HREADY_o=1.
  - When it reaches TIMEOUT_CYCLES, the mux forces HDEF_o=1 and FSM to DS_ERR1, producing the two-cycle ERROR.
  - The hung slave's later HREADYOUT/HRESP are ignored.
  - A 1-cycle pulse is driven on extra output HTIMEOUT_o.
- Undefined: no counter and no HTIMEOUT_o port; slave waits are unlimited.

Decomposition:
- Shared package ahb_pkg holds:
  - HRESP codes (AHB_OKAY, AHB_ERROR, AHB_RETRY, AHB_SPLIT);
  - HTRANS codes (AHB_IDLE, AHB_BUSY, AHB_NONSEQ, AHB_SEQ);
  - enum ds_state_t.
- `AHB_BUS_WIDTH stays in ahb_defines.v.
- One sub-module: ahb_default_slave, containing the FSM and timeout counter. The mux top keeps the select register and steering.

Test Plan:
1. Read from slave 3 (HSEL_i=16'h0008, NONSEQ), slave returns HRDATA=32'hDEADBEEF after 2 wait states -> HREADY_o low 2 cycles, then 1 with HRDATA_o=DEADBEEF, HRESP_o=00, HSLAVE_o=3.
2. NONSEQ with HSEL_i=0 -> DS_ERR1 (HREADY_o=0, HRESP_o=01), then DS_ERR2 (HREADY_o=1, HRESP_o=01), then OKAY; HDEF_o=1 throughout.
3. IDLE with HSEL_i=0 -> HREADY_o=1, HRESP_o=00, no error cycles.
4. Slave 0 read held in wait while HSEL_i switches to slave 5 -> select does not change until HREADY_o=1; the next data phase comes from slave 5.
5. HSEL_i=16'h0030 (bits 4 and 5) -> HSLAVE_o=4, response from slave 4.
6. Assert HRST_N=0 during DS_ERR1 -> immediately HREADY_o=1, HRESP_o=00, HDEF_o=1. With AHB_READ_TIMEOUT_EN and TIMEOUT_CYCLES=8, a slave held at HREADYOUT=0 -> ERROR after 8 wait cycles and a single HTIMEOUT_o pulse.
